writeback_regfile: RTL and testbench

//  Y86-64 SEQ write-back stage: 15x64-bit register file plus processor status register.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/regfile_2r2w.sv | 55 +++++
 rtl/writeback_regfile.sv | 89 ++++++++
 tb/tb_writeback_regfile.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: status codes, register IDs and instruction codes.
package y86_pkg;

    localparam int unsigned STAT_W   = 3;
    localparam int unsigned REG_ID_W = 4;
    localparam int unsigned ICODE_W  = 4;
    localparam int unsigned RET_W    = 32;

    localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
    localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
    localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
    localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

    localparam logic [REG_ID_W-1:0] RNONE   = 4'hF;
    localparam logic [REG_ID_W-1:0] REG_RSP = 4'd4;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    // Status an instruction would leave behind; ADR outranks INS outranks HLT.
    function automatic logic [STAT_W-1:0] next_stat(
        input logic               imem_err,
        input logic               dmem_err,
        input logic               instr_err,
        input logic [ICODE_W-1:0] icode
    );
        if (imem_err || dmem_err) return STAT_ADR;
        if (instr_err)            return STAT_INS;
        if (icode == I_HALT)      return STAT_HLT;
        return STAT_AOK;
    endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Register file with two async read ports and two sync write ports; port 1 wins on collision.
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int unsigned          DATA_W     = 64,
    parameter int unsigned          NREGS      = 15,
    parameter logic [DATA_W-1:0]    STACK_INIT = DATA_W'(504)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we1,
    input  logic [REG_ID_W-1:0] wa1,
    input  logic [DATA_W-1:0]   wd1,
    input  logic                we2,
    input  logic [REG_ID_W-1:0] wa2,
    input  logic [DATA_W-1:0]   wd2,
    input  logic [REG_ID_W-1:0] ra1,
    output logic [DATA_W-1:0]   rd1,
    input  logic [REG_ID_W-1:0] ra2,
    output logic [DATA_W-1:0]   rd2
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Out-of-range or RNONE addresses never match an entry, so they write nothing.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we2 && (wa2 == REG_ID_W'(i))) regs_d[i] = wd2;
            if (we1 && (wa1 == REG_ID_W'(i))) regs_d[i] = wd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (REG_ID_W'(i) == REG_RSP) ? STACK_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Unmatched read addresses return zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (ra1 == REG_ID_W'(i)) rd1 = regs_q[i];
            if (ra2 == REG_ID_W'(i)) rd2 = regs_q[i];
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back: register file commit, sticky processor status and retire counter.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int unsigned          DATA_W     = 64,
    parameter int unsigned          NREGS      = 15,
    parameter logic [DATA_W-1:0]    STACK_INIT = DATA_W'(504)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [ICODE_W-1:0]  icode,
    input  logic                instr_err,
    input  logic                imem_error,
    input  logic                dmem_error,
    input  logic [REG_ID_W-1:0] dstE,
    input  logic [REG_ID_W-1:0] dstM,
    input  logic [DATA_W-1:0]   valE,
    input  logic [DATA_W-1:0]   valM,
    input  logic [REG_ID_W-1:0] srcA,
    input  logic [REG_ID_W-1:0] srcB,
    output logic [DATA_W-1:0]   valA,
    output logic [DATA_W-1:0]   valB,
    output logic [STAT_W-1:0]   stat,
    output logic                halted,
    output logic [RET_W-1:0]    retired
);

    logic [STAT_W-1:0] stat_q,    stat_d;
    logic              halted_q,  halted_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic [STAT_W-1:0] nstat;
    logic              commit;
    logic              wr_en;

    // Once stat leaves AOK nothing commits until reset.
    always_comb begin
        nstat     = next_stat(imem_error, dmem_error, instr_err, icode);
        commit    = instr_valid && (stat_q == STAT_AOK);
        wr_en     = commit && (nstat == STAT_AOK);
        stat_d    = stat_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (commit) begin
            stat_d   = nstat;
            halted_d = (nstat != STAT_AOK);
            if ((nstat == STAT_AOK) || (nstat == STAT_HLT)) begin
                retired_d = retired_q + RET_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q    <= STAT_AOK;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            stat_q    <= stat_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // Port 1 carries valM so a popq %rsp collision resolves to the loaded value.
    regfile_2r2w #(
        .DATA_W     (DATA_W),
        .NREGS      (NREGS),
        .STACK_INIT (STACK_INIT)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we1   (wr_en && (dstM != RNONE)),
        .wa1   (dstM),
        .wd1   (valM),
        .we2   (wr_en && (dstE != RNONE)),
        .wa2   (dstE),
        .wd2   (valE),
        .ra1   (srcA),
        .rd1   (valA),
        .ra2   (srcB),
        .rd2   (valB)
    );

    assign stat    = stat_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile against a small architectural model.
`timescale 1ns/1ps
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [3:0]  icode;
    logic        instr_err, imem_error, dmem_error;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic [63:0] valE, valM, valA, valB;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .icode(icode),
        .instr_err(instr_err), .imem_error(imem_error), .dmem_error(dmem_error),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .stat(stat), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic        halted;
        logic [31:0] retired;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_regs [15];
    logic [2:0]  m_stat;
    logic [31:0] m_ret;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [3:0] id);
        if (id >= 4'd15) return 64'd0;
        return m_regs[id];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? 64'd504 : 64'd0;
        m_stat = 3'd1;
        m_ret  = 32'd0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i);
            srcB = 4'(15 - i);
            #1;
            chk({tag, "_valA"}, valA, m_read(4'(i)));
            chk({tag, "_valB"}, valB, m_read(4'(15 - i)));
        end
    endtask

    // Drive one instruction, push the model's post-edge view, then pop and compare after the edge.
    task automatic step(input string tag, input logic v, input logic [3:0] ic,
                        input logic ie, input logic ime, input logic dme,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [63:0] ve, input logic [63:0] vm);
        logic [2:0] ns;
        exp_t       e;
        @(negedge clk);
        instr_valid = v; icode = ic; instr_err = ie; imem_error = ime; dmem_error = dme;
        dstE = de; dstM = dm; valE = ve; valM = vm;
        srcA = de; srcB = dm;
        #1;
        chk({tag, "_pre_valA"}, valA, m_read(de));
        chk({tag, "_pre_valB"}, valB, m_read(dm));
        if (v && m_stat == 3'd1) begin
            ns = (ime || dme) ? 3'd3 : ie ? 3'd4 : (ic == 4'h0) ? 3'd2 : 3'd1;
            if (ns == 3'd1) begin
                if (de < 4'd15) m_regs[de] = ve;
                if (dm < 4'd15) m_regs[dm] = vm;
            end
            if (ns == 3'd1 || ns == 3'd2) m_ret = m_ret + 32'd1;
            m_stat = ns;
        end
        e.stat = m_stat; e.halted = (m_stat != 3'd1); e.retired = m_ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_stat"},    64'(stat),    64'(e.stat));
            chk({tag, "_halted"},  64'(halted),  64'(e.halted));
            chk({tag, "_retired"}, 64'(retired), 64'(e.retired));
        end
    endtask

    // Reset is pulsed between edges and checked while still asserted.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        srcA = 4'd4; srcB = 4'd0;
        #1;
        chk({tag, "_rsp"},     valA, 64'd504);
        chk({tag, "_r0"},      valB, 64'd0);
        chk({tag, "_stat"},    64'(stat), 64'd1);
        chk({tag, "_halted"},  64'(halted), 64'd0);
        chk({tag, "_retired"}, 64'(retired), 64'd0);
        srcA = 4'hF;
        #1;
        chk({tag, "_rnone"},   valA, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; instr_valid = 1'b0; icode = 4'h1;
        instr_err = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF;
        model_reset();
        pulse_reset("rst0");
        check_all_regs("rst0");

        step("dual",  1, 4'h6, 0, 0, 0, 4'd2, 4'd3, 64'h11, 64'h22);
        check_all_regs("dual");
        step("novalid", 0, 4'h6, 0, 0, 0, 4'd6, 4'd7, 64'h55, 64'h66);
        step("collide", 1, 4'hB, 0, 0, 0, 4'd4, 4'd4, 64'h1F8, 64'hAA);
        step("r14",   1, 4'h3, 0, 0, 0, 4'd14, 4'hF, 64'hDEAD_BEEF_0123_4567, 64'h0);
        for (int k = 0; k < 6; k++)
            step("rand", 1, 4'h6, 0, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, {$urandom, $urandom});
        check_all_regs("run");
        step("dmerr", 1, 4'h5, 0, 0, 1, 4'hF, 4'd5, 64'h0, 64'h7);
        step("frozen", 1, 4'h6, 0, 0, 0, 4'd1, 4'hF, 64'h99, 64'h0);
        step("frozen_hlt", 1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 64'h0, 64'h0);
        check_all_regs("dmerr");

        pulse_reset("rst1");
        step("pre_hlt", 1, 4'h2, 0, 0, 0, 4'd0, 4'hF, 64'h33, 64'h0);
        step("halt",  1, 4'h0, 0, 0, 0, 4'd5, 4'd6, 64'h44, 64'h45);
        step("post_hlt", 1, 4'h6, 0, 0, 0, 4'd7, 4'hF, 64'h46, 64'h0);
        check_all_regs("halt");

        pulse_reset("rst2");
        step("ins",   1, 4'h6, 1, 0, 0, 4'd1, 4'hF, 64'h12, 64'h0);
        pulse_reset("rst3");
        step("ins_adr", 1, 4'h0, 1, 0, 1, 4'd1, 4'd2, 64'h12, 64'h13);
        pulse_reset("rst4");
        step("imerr", 1, 4'h1, 0, 1, 0, 4'hF, 4'hF, 64'h0, 64'h0);
        pulse_reset("rst5");
        step("ok1", 1, 4'h3, 0, 0, 0, 4'd8, 4'hF, 64'h77, 64'h0);
        check_all_regs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
